// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner: FSM encoding,
// counter widths and row-sense classification.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } kp_state_t;

  typedef enum logic [1:0] {
    ROW_CLS_IDLE   = 2'd0,
    ROW_CLS_SINGLE = 2'd1,
    ROW_CLS_MULTI  = 2'd2
  } row_class_t;

  localparam logic [3:0] ROW_IDLE = 4'hF;
  localparam int         COL_W    = 2;
  localparam int         CNT_W    = 4;

  // Rows are active-low: count the zeros to tell idle, single key and ghosting apart.
  function automatic row_class_t classify_row(input logic [3:0] row);
    int zeros;
    zeros = 0;
    for (int i = 0; i < 4; i++) begin
      if (!row[i]) zeros++;
    end
    if (zeros == 0)      return ROW_CLS_IDLE;
    else if (zeros == 1) return ROW_CLS_SINGLE;
    else                 return ROW_CLS_MULTI;
  endfunction

  function automatic logic [1:0] row_index(input logic [3:0] row);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!row[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scan_4x4_tick_gen.sv
// Free-running divider producing a one-cycle tick at the end of every
// DIV-cycle column dwell.
module tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk_50mhz,
  input  logic rst,
  output logic tick
);

  localparam int              DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] div_cnt_reg;

  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      div_cnt_reg <= '0;
    end else if (div_cnt_reg == DIV_LAST) begin
      div_cnt_reg <= '0;
    end else begin
      div_cnt_reg <= div_cnt_reg + 1'b1;
    end
  end

  assign tick = (div_cnt_reg == DIV_LAST);

endmodule

// File: rtl/keypad_scan_4x4.sv
// 4x4 active-low keypad scanner: rotates the column drive, debounces a single
// pressed key and its release, and emits one key_valid strobe per press.
module keypad_scan_4x4
  import keypad_pkg::*;
#(
  parameter int CLK_HZ         = 50000000,
  parameter int SCAN_HZ        = 1000,
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic       clk_50mhz,
  input  logic       rst,
  output logic [3:0] key_col,
  input  logic [3:0] key_row,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int               DIV       = CLK_HZ / SCAN_HZ;
  localparam logic [CNT_W-1:0] DB_TARGET = CNT_W'(DEBOUNCE_TICKS);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic             tick;
  logic [3:0]       row_meta_reg;
  logic [3:0]       row_s;
  row_class_t       row_cls;

  kp_state_t        state_reg, state_next;
  logic [COL_W-1:0] col_idx_reg, col_idx_next;
  logic [COL_W-1:0] lat_col_reg, lat_col_next;
  logic [3:0]       lat_row_reg, lat_row_next;
  logic [CNT_W-1:0] db_cnt_reg, db_cnt_next;
  logic [CNT_W-1:0] rel_cnt_reg, rel_cnt_next;
  logic [3:0]       key_code_reg, key_code_next;
  logic             key_valid_reg, key_valid_next;
  logic             key_held_reg, key_held_next;
  logic [CNT_W-1:0] db_cnt_inc, rel_cnt_inc;

  tick_gen #(.DIV(DIV)) u_tick_gen (
    .clk_50mhz (clk_50mhz),
    .rst       (rst),
    .tick      (tick)
  );

  // Rows are asynchronous; two flops per bit, idling high like the pull-ups.
  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      row_meta_reg <= 4'hF;
      row_s        <= 4'hF;
    end else begin
      row_meta_reg <= key_row;
      row_s        <= row_meta_reg;
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_col_drive
      assign key_col[gi] = (col_idx_reg != COL_W'(gi));
    end
  endgenerate

  assign row_cls     = classify_row(row_s);
  assign db_cnt_inc  = db_cnt_reg + 1'b1;
  assign rel_cnt_inc = rel_cnt_reg + 1'b1;

  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      state_reg     <= SCAN;
      col_idx_reg   <= '0;
      lat_col_reg   <= '0;
      lat_row_reg   <= ROW_IDLE;
      db_cnt_reg    <= '0;
      rel_cnt_reg   <= '0;
      key_code_reg  <= 4'h0;
      key_valid_reg <= 1'b0;
      key_held_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      col_idx_reg   <= col_idx_next;
      lat_col_reg   <= lat_col_next;
      lat_row_reg   <= lat_row_next;
      db_cnt_reg    <= db_cnt_next;
      rel_cnt_reg   <= rel_cnt_next;
      key_code_reg  <= key_code_next;
      key_valid_reg <= key_valid_next;
      key_held_reg  <= key_held_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    col_idx_next   = col_idx_reg;
    lat_col_next   = lat_col_reg;
    lat_row_next   = lat_row_reg;
    db_cnt_next    = db_cnt_reg;
    rel_cnt_next   = rel_cnt_reg;
    key_code_next  = key_code_reg;
    key_valid_next = 1'b0;
    key_held_next  = key_held_reg;

    if (tick) begin
      case (state_reg)
        SCAN: begin
          if (row_cls == ROW_CLS_SINGLE) begin
            lat_row_next = row_s;
            lat_col_next = col_idx_reg;
            db_cnt_next  = CNT_ONE;
            // A single-tick debounce accepts on the very first sighting.
            if (DB_TARGET == CNT_ONE) begin
              key_code_next  = {row_index(row_s), col_idx_reg};
              key_valid_next = 1'b1;
              key_held_next  = 1'b1;
              rel_cnt_next   = '0;
              state_next     = HELD;
            end else begin
              state_next = DEBOUNCE;
            end
          end else begin
            col_idx_next = col_idx_reg + 1'b1;
          end
        end
        DEBOUNCE: begin
          if (row_s == lat_row_reg) begin
            db_cnt_next = db_cnt_inc;
            if (db_cnt_inc == DB_TARGET) begin
              key_code_next  = {row_index(lat_row_reg), lat_col_reg};
              key_valid_next = 1'b1;
              key_held_next  = 1'b1;
              rel_cnt_next   = '0;
              state_next     = HELD;
            end
          end else begin
            col_idx_next = col_idx_reg + 1'b1;
            state_next   = SCAN;
          end
        end
        HELD: begin
          if (row_s == ROW_IDLE) begin
            rel_cnt_next = rel_cnt_inc;
            if (rel_cnt_inc == DB_TARGET) begin
              key_held_next = 1'b0;
              col_idx_next  = col_idx_reg + 1'b1;
              state_next    = SCAN;
            end
          end else begin
            rel_cnt_next = '0;
          end
        end
        default: state_next = SCAN;
      endcase
    end
  end

  assign key_code  = key_code_reg;
  assign key_valid = key_valid_reg;
  assign key_held  = key_held_reg;

endmodule

// File: tb/tb_keypad_scan_4x4.sv
// Directed bench for keypad_scan_4x4 with a key-matrix model and a queue of
// expected key codes consumed on every key_valid strobe.
module tb_keypad_scan_4x4;

  logic        clk_50mhz;
  logic        rst;
  logic [3:0]  key_col;
  logic [3:0]  key_row;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;

  logic [15:0] pressed;
  logic [3:0]  exp_q[$];
  int          n_checks;
  int          n_fail;

  keypad_scan_4x4 #(
    .CLK_HZ         (1000),
    .SCAN_HZ        (100),
    .DEBOUNCE_TICKS (3)
  ) dut (
    .clk_50mhz (clk_50mhz),
    .rst       (rst),
    .key_col   (key_col),
    .key_row   (key_row),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  initial clk_50mhz = 1'b0;
  always #5 clk_50mhz = ~clk_50mhz;

  // Key (r,c) shorts row r to column c; pressed index is r*4+c.
  always_comb begin
    key_row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      if (|(pressed[r*4 +: 4] & ~key_col)) key_row[r] = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Advance n cycles, sampling on the falling edge and scoring every strobe.
  task automatic run_cycles(input int n);
    logic [3:0] e;
    repeat (n) begin
      @(negedge clk_50mhz);
      if (key_valid === 1'b1) begin
        n_checks++;
        assert (exp_q.size() > 0) else begin
          n_fail++;
          $error("FAIL unexpected_valid: observed pulse with code %0h expected no pulse", key_code);
        end
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("key_code", {28'd0, key_code}, {28'd0, e});
        end
      end
    end
  endtask

  task automatic wait_release(input string name, input int bound);
    int cnt;
    cnt = 0;
    while (key_held === 1'b1 && cnt < bound) begin
      run_cycles(1);
      cnt++;
    end
    check(name, {31'd0, key_held}, 32'd0);
  endtask

  task automatic wait_col(input logic [3:0] col, input int bound);
    int cnt;
    cnt = 0;
    while (key_col !== col && cnt < bound) begin
      run_cycles(1);
      cnt++;
    end
    check("wait_col", {28'd0, key_col}, {28'd0, col});
  endtask

  initial begin
    logic [3:0] seen;
    n_checks = 0;
    n_fail   = 0;
    pressed  = 16'h0;
    rst      = 1'b1;

    // Reset state
    repeat (5) @(negedge clk_50mhz);
    check("rst_key_col",   {28'd0, key_col},   32'hE);
    check("rst_key_code",  {28'd0, key_code},  32'h0);
    check("rst_key_valid", {31'd0, key_valid}, 32'd0);
    check("rst_key_held",  {31'd0, key_held},  32'd0);

    // Column rotation with no key pressed
    rst = 1'b0;
    check("rot_0", {28'd0, key_col}, 32'hE);
    run_cycles(10); check("rot_1", {28'd0, key_col}, 32'hD);
    run_cycles(10); check("rot_2", {28'd0, key_col}, 32'hB);
    run_cycles(10); check("rot_3", {28'd0, key_col}, 32'h7);
    run_cycles(10); check("rot_4", {28'd0, key_col}, 32'hE);

    // Single press of row 2 / col 1
    pressed = 16'h0200;
    exp_q.push_back(4'h9);
    run_cycles(200);
    check("single_q_empty", exp_q.size(), 32'd0);
    check("single_held", {31'd0, key_held}, 32'd1);
    pressed = 16'h0;
    wait_release("single_release", 45);
    check("single_resume_col2", {28'd0, key_col}, 32'hB);
    check("single_code_holds", {28'd0, key_code}, 32'h9);

    // Bouncing press of row 0 / col 3, then stable
    for (int i = 0; i < 60; i++) begin
      if (i % 7 == 0) pressed = pressed ^ 16'h0008;
      run_cycles(1);
    end
    pressed = 16'h0008;
    exp_q.push_back(4'h3);
    run_cycles(100);
    check("bounce_q_empty", exp_q.size(), 32'd0);
    pressed = 16'h0;
    wait_release("bounce_release", 45);

    // Ghosting: rows 0 and 1 on col 0
    pressed = 16'h0011;
    seen = 4'h0;
    for (int i = 0; i < 100; i++) begin
      run_cycles(1);
      for (int c = 0; c < 4; c++) if (key_col[c] === 1'b0) seen[c] = 1'b1;
    end
    check("ghost_cols_rotate", {28'd0, seen}, 32'hF);
    check("ghost_held", {31'd0, key_held}, 32'd0);
    check("ghost_q_empty", exp_q.size(), 32'd0);
    pressed = 16'h0;
    run_cycles(20);

    // Second key while held
    pressed = 16'h0020;
    exp_q.push_back(4'h5);
    run_cycles(100);
    check("hold5_held", {31'd0, key_held}, 32'd1);
    pressed = 16'h0420;
    run_cycles(100);
    check("second_ignored_q", exp_q.size(), 32'd0);
    check("second_code", {28'd0, key_code}, 32'h5);
    pressed = 16'h0;
    wait_release("both_release", 45);
    pressed = 16'h0400;
    exp_q.push_back(4'hA);
    run_cycles(100);
    check("keyA_q_empty", exp_q.size(), 32'd0);
    pressed = 16'h0;
    wait_release("keyA_release", 45);

    // Reset one tick into debounce with key F pressed
    wait_col(4'h7, 60);
    pressed = 16'h8000;
    run_cycles(12);
    rst = 1'b1;
    run_cycles(5);
    check("mid_rst_key_col",   {28'd0, key_col},   32'hE);
    check("mid_rst_key_code",  {28'd0, key_code},  32'h0);
    check("mid_rst_key_valid", {31'd0, key_valid}, 32'd0);
    check("mid_rst_key_held",  {31'd0, key_held},  32'd0);
    rst = 1'b0;
    exp_q.push_back(4'hF);
    run_cycles(120);
    check("keyF_q_empty", exp_q.size(), 32'd0);
    check("keyF_held", {31'd0, key_held}, 32'd1);
    pressed = 16'h0;
    wait_release("keyF_release", 45);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
